clk_gen_sweep_ctrl: RTL
=======================

Name: clk_gen_sweep_ctrl

Overview:
- Sequencer that drives the period input and enable of the programmable clock divider.
- Steps the divider's half-period through a programmed range: start, stop, step and dwell.
- Each point is held for a fixed number of divider overflow events.
- Used by the spectrograph/correlator to scan sampling rates without host intervention per point.
- Sits between the host config registers and the divider instance; one controller per divider.

Parameters:
- RESOLUTION, 32, width of the period word (ns) driven to the divider
- DWELL_WIDTH, 16, width of the dwell counter (overflow events per point)

Ports:
- clk  in  1  system clock, same clock as the divider
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  host presents a sweep configuration
- cfg_ready  out  1  controller can accept a configuration (IDLE only)
- cfg_start  in  RESOLUTION  first period value
- cfg_stop  in  RESOLUTION  last period value (inclusive bound)
- cfg_step  in  RESOLUTION  magnitude of the period increment
- cfg_dwell  in  DWELL_WIDTH  overflow events per point
- abort  in  1  terminate the sweep
- ns  out  RESOLUTION  period word to the divider
- gen_enable  out  1  divider enable
- gen_overflow  in  1  divider overflow pulse (one per output toggle)
- busy  out  1  sweep in progress (ARM or RUN)
- step_strobe  out  1  one-cycle pulse when ns advances to a new point
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state=IDLE, ns=0, gen_enable=0, cfg_ready=1, busy=0, step_strobe=0, done=0, dwell count=0, shadow registers=0.
- All outputs are registered. Reset takes priority over every other input.

IDLE:
- cfg_ready=1, gen_enable=0.
- On cfg_valid (handshake completes that cycle):
  - latch start/stop/step/dwell into shadow registers;
  - ns<=cfg_start;
  - direction latched: ascending if cfg_start<=cfg_stop, else descending;
  - next state ARM.
- abort is ignored in IDLE. cfg_valid together with abort is accepted.

ARM:
- Lasts exactly one cycle. gen_enable=0, busy=1, cfg_ready=0, dwell count cleared.
- This forces divider clk_out low before the first point. Next state RUN.
- Latency: accept at cycle N, gen_enable=1 visible at cycle N+2.

RUN:
- gen_enable=1, busy=1.
- Each cycle with gen_overflow=1 increments the dwell count.
- Dwell is complete on the overflow that brings the count to dwell.
- cfg_dwell=0 is treated as 1.
- On dwell complete, compute next=ns±step in RESOLUTION+1 bits.
  - Finish condition: ns==stop, or step==0, or next passes stop (ascending next>stop or carry-out; descending ns<step or next<stop).
  - If the finish condition holds: go to DONE.
  - Otherwise: ns<=next, step_strobe=1 for one cycle, dwell count<=0, stay in RUN. gen_enable stays high across points (no gap).
- Overshoot never emits a point outside [min(start,stop), max(start,stop)]. The last point is the final in-range value.
- cfg_valid is ignored while busy (cfg_ready=0).

DONE:
- One cycle: gen_enable=0, done=1, busy=0, ns holds the last point. Next state IDLE.

abort:
- In ARM or RUN: next cycle state=IDLE, gen_enable=0, busy=0, cfg_ready=1.
- No done pulse and no step_strobe, even if dwell completes in the same cycle. ns holds its value.

Other rules:
- gen_overflow outside RUN is ignored.
- step_strobe and done never assert in the same cycle.

Test Plan:
- Reset check: assert reset 2 cycles with cfg_valid=1 -> all outputs at reset values, cfg_ready=1, no config latched.
- Ascending sweep: start=10, stop=30, step=10, dwell=2, model divider overflow every 4 cycles -> ns sequence 10,20,30; step_strobe pulses twice; done pulse after 2nd overflow at 30; gen_enable high continuously from accept+2 until DONE.
- Descending overshoot: start=25, stop=5, step=10, dwell=1 -> points 25,15,5; then start=25, stop=6 -> points 25,15 only, done after 15; ns never below 6.
- Edge configs: step=0, dwell=0 -> single point, done after first overflow. Start=2^32-3, stop=2^32-1, step=4 -> single point, carry-out treated as finish.
- Abort mid-RUN coincident with dwell-completing overflow -> IDLE next cycle, gen_enable=0, no done, no step_strobe, cfg_ready=1. A new cfg accepted the following cycle.
- Handshake: cfg_valid held during RUN with different values -> ignored, shadow unchanged. Abort+cfg_valid in IDLE -> config accepted, ARM entered.

Source files
------------

// File: rtl/clk_gen_sweep_ctrl_if.sv
// rtl/clk_gen_sweep_ctrl_if.sv - sweep configuration handshake and divider drive bundle
interface clk_gen_sweep_ctrl_if #(
   parameter int RESOLUTION  = 32,
   parameter int DWELL_WIDTH = 16
);
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [RESOLUTION-1:0]  cfg_start;
   logic [RESOLUTION-1:0]  cfg_stop;
   logic [RESOLUTION-1:0]  cfg_step;
   logic [DWELL_WIDTH-1:0] cfg_dwell;
   logic [RESOLUTION-1:0]  ns;
   logic                   gen_enable;
   logic                   gen_overflow;

   // Host/divider side.
   modport master (
      output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, gen_overflow,
      input  cfg_ready, ns, gen_enable
   );

   // Sweep controller side.
   modport slave (
      input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, gen_overflow,
      output cfg_ready, ns, gen_enable
   );
endinterface

// File: rtl/clk_gen_sweep_ctrl.sv
// rtl/clk_gen_sweep_ctrl.sv - steps a clock divider's period through start..stop with a per-point dwell
module clk_gen_sweep_ctrl #(
   parameter int RESOLUTION  = 32,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   clk_gen_sweep_ctrl_if.slave  cfg,
   input  logic                 abort,
   output logic                 busy,
   output logic                 step_strobe,
   output logic                 done
);
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [RESOLUTION-1:0]  ns_q, ns_d;
   logic [RESOLUTION-1:0]  stop_q, stop_d;
   logic [RESOLUTION-1:0]  step_q, step_d;
   logic [DWELL_WIDTH-1:0] dwell_cfg_q, dwell_cfg_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic                   desc_q, desc_d;
   logic                   en_q, en_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   strobe_q, strobe_d;
   logic                   done_q, done_d;

   logic [DWELL_WIDTH-1:0] dwell_lim;
   logic [DWELL_WIDTH:0]   dwell_inc;
   logic                   dwell_hit;
   logic [RESOLUTION:0]    sum;
   logic [RESOLUTION:0]    diff;
   logic                   finish;

   // A zero dwell still holds each point for one overflow.
   assign dwell_lim = (dwell_cfg_q == '0) ? DWELL_WIDTH'(1) : dwell_cfg_q;
   assign dwell_inc = {1'b0, dwell_q} + 1'b1;
   assign dwell_hit = cfg.gen_overflow && (dwell_inc == {1'b0, dwell_lim});

   // The extra top bit is carry-out (ascending) or borrow (descending).
   assign sum  = {1'b0, ns_q} + {1'b0, step_q};
   assign diff = {1'b0, ns_q} - {1'b0, step_q};
   assign finish = (ns_q == stop_q) || (step_q == '0) ||
                   (desc_q ? (diff[RESOLUTION] || (diff[RESOLUTION-1:0] < stop_q))
                           : (sum[RESOLUTION]  || (sum[RESOLUTION-1:0]  > stop_q)));

   always_comb begin
      state_d     = state_q;
      ns_d        = ns_q;
      stop_d      = stop_q;
      step_d      = step_q;
      dwell_cfg_d = dwell_cfg_q;
      dwell_d     = dwell_q;
      desc_d      = desc_q;
      en_d        = en_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      strobe_d    = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cfg.cfg_valid) begin
               stop_d      = cfg.cfg_stop;
               step_d      = cfg.cfg_step;
               dwell_cfg_d = cfg.cfg_dwell;
               ns_d        = cfg.cfg_start;
               desc_d      = cfg.cfg_start > cfg.cfg_stop;
               dwell_d     = '0;
               state_d     = S_ARM;
               ready_d     = 1'b0;
               busy_d      = 1'b1;
               en_d        = 1'b0;
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d = S_IDLE;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               state_d = S_RUN;
               en_d    = 1'b1;
               dwell_d = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else if (dwell_hit) begin
               if (finish) begin
                  state_d = S_DONE;
                  en_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  ns_d     = desc_q ? diff[RESOLUTION-1:0] : sum[RESOLUTION-1:0];
                  strobe_d = 1'b1;
                  dwell_d  = '0;
               end
            end else if (cfg.gen_overflow) begin
               dwell_d = dwell_inc[DWELL_WIDTH-1:0];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ns_q        <= '0;
         stop_q      <= '0;
         step_q      <= '0;
         dwell_cfg_q <= '0;
         dwell_q     <= '0;
         desc_q      <= 1'b0;
         en_q        <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         strobe_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ns_q        <= ns_d;
         stop_q      <= stop_d;
         step_q      <= step_d;
         dwell_cfg_q <= dwell_cfg_d;
         dwell_q     <= dwell_d;
         desc_q      <= desc_d;
         en_q        <= en_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         strobe_q    <= strobe_d;
         done_q      <= done_d;
      end
   end

   assign cfg.cfg_ready  = ready_q;
   assign cfg.ns         = ns_q;
   assign cfg.gen_enable = en_q;
   assign busy           = busy_q;
   assign step_strobe    = strobe_q;
   assign done           = done_q;
endmodule
